prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: idle clock cycles allowed between accepted load bytes before the load aborts.
REQ-002 Parameter HALT_WORD, default 8'hFF: word returned for any unloaded address (jump, immediate -1, so the core spins in place).
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  single-cycle request to begin a new program load.
REQ-006 load_valid  input  1  loader byte valid.
REQ-007 load_data  input  8  loader byte.
REQ-008 load_ready  output  1  block accepts a byte this cycle.
REQ-009 instruction_address  input  8  core fetch address (core PC).
REQ-010 instruction  output  8  fetched instruction word to the core.
REQ-011 cpu_reset  output  1  holds the core in reset while no valid program is present.
REQ-012 running  output  1  a valid program is loaded and the core is released.
REQ-013 error  output  1  the last load aborted.
REQ-014 byte_count  output  8  number of data bytes written in the current or last load.

Function
REQ-015 States: IDLE, LEN, DATA, CSUM (only when the Configuration macro is defined), RUN, ERROR.
REQ-016 A byte transfers only on a clock edge with load_valid=1 and load_ready=1.
REQ-017 load_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in all other states.
REQ-018 load_start=1 in any state SHALL enter LEN on the next edge, clear byte_count, running and error, and abort any load in progress; it takes priority over a simultaneous transfer.
REQ-019 LEN: the first byte transferred is the program length L; L=0 enters ERROR, and L=1..255 stores L and enters DATA.
REQ-020 DATA: byte k (k=0..L-1) is written to memory address k and byte_count increments; after byte L-1 the block enters CSUM if the macro is defined, otherwise RUN.
REQ-021 RUN: cpu_reset=0 and running=1; the state is held until load_start or reset.
REQ-022 ERROR: error=1 and cpu_reset=1; the state is held until load_start or reset.
REQ-023 cpu_reset SHALL be 1 in every state except RUN, and SHALL fall on the same edge that enters RUN.
REQ-024 In RUN, instruction SHALL equal mem[instruction_address] when instruction_address < L, and HALT_WORD otherwise, as a combinational read with zero-cycle latency.
REQ-025 In every state other than RUN, instruction SHALL equal HALT_WORD.
REQ-026 Timeout counter: cleared on entering LEN and on every transfer, incremented each cycle in LEN, DATA and CSUM; reaching TIMEOUT_CYCLES enters ERROR.
REQ-027 Memory is 256x8, written only in DATA; unwritten locations keep their prior contents but are masked by REQ-024.
REQ-028 byte_count wraps never; its maximum is 255.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, L=0, byte_count=0, running=0, error=0, cpu_reset=1, load_ready=0 and instruction=HALT_WORD.
REQ-030 Reset during a load SHALL abandon the load; the memory array itself is not cleared.
REQ-031 From IDLE, the only exit is load_start.

Configuration
REQ-032 Macro PROG_LOADER_CHECKSUM_EN, when defined, adds state CSUM: the next transferred byte is compared with the mod-256 sum of the L data bytes.
REQ-033 With PROG_LOADER_CHECKSUM_EN defined, a checksum match enters RUN and a mismatch enters ERROR.
REQ-034 Without PROG_LOADER_CHECKSUM_EN, CSUM is absent, DATA goes directly to RUN, and no extra byte is consumed.

Verification
REQ-035 Reset, pulse load_start, send bytes 03,00,15,C3 (plus checksum D8 if the macro is defined) -> running=1, cpu_reset=0, byte_count=3; addresses 0/1/2 read 00/15/C3; address 3 and 200 read FF.
REQ-036 Checksum build: send 02,11,22 then checksum 34 -> error=1, cpu_reset=1, instruction=FF; then load_start with a correct stream -> RUN.
REQ-037 Send length 05 and two data bytes, then stall TIMEOUT_CYCLES cycles -> ERROR, byte_count=2.
REQ-038 Send length 00 -> ERROR on the same edge as the transfer; load_ready=0 afterwards.
REQ-039 Assert load_start while in RUN with a simultaneous load_valid -> the byte is ignored, the state is LEN, cpu_reset=1 on the next edge, instruction=FF.
REQ-040 Assert reset mid-DATA, deassert it, and hold load_valid=1 -> state stays IDLE, load_ready=0, no memory writes, instruction=FF.

Source files
------------

// File: rtl/prog_loader_if.sv
// Loader byte stream, core fetch port and status lines of prog_loader; slave = the loader block.
interface prog_loader_if;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] instruction_address;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic       running;
  logic       error;
  logic [7:0] byte_count;

  modport slave (
    input  load_start, load_valid, load_data, instruction_address,
    output load_ready, instruction, cpu_reset, running, error, byte_count
  );

  modport master (
    output load_start, load_valid, load_data, instruction_address,
    input  load_ready, instruction, cpu_reset, running, error, byte_count
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed program into 256x8 memory and serves zero-latency fetches once valid;
// load_ready is high only while a load is in progress. PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  HALT_WORD      = 8'hFF
) (
  input logic          clock,
  input logic          reset,
  prog_loader_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_count;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_mem [256];

  state_t        w_state_nxt;
  logic [7:0]    w_len_nxt;
  logic [7:0]    w_count_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_mem_we;
  logic          w_loading;
  logic          w_xfer;
  logic          w_timeout;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
  logic [7:0]    w_sum_nxt;
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_loading = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_loading = (r_state == S_LEN) || (r_state == S_DATA);
`endif
  assign w_xfer    = w_loading && bus.load_valid;
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_timer_nxt = r_timer;
    w_mem_we    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif
    if (bus.load_start) begin
      // A new request wins over any byte offered on the same edge.
      w_state_nxt = S_LEN;
      w_len_nxt   = '0;
      w_count_nxt = '0;
      w_timer_nxt = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      w_sum_nxt   = '0;
`endif
    end else if (w_loading) begin
      if (w_xfer) begin
        w_timer_nxt = '0;
        case (r_state)
          S_LEN: begin
            if (bus.load_data == 8'd0) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_len_nxt   = bus.load_data;
              w_state_nxt = S_DATA;
            end
          end
          S_DATA: begin
            w_mem_we    = 1'b1;
            w_count_nxt = r_count + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            w_sum_nxt   = r_sum + bus.load_data;
            if (r_count == r_len - 8'd1) w_state_nxt = S_CSUM;
`else
            if (r_count == r_len - 8'd1) w_state_nxt = S_RUN;
`endif
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CSUM: w_state_nxt = (bus.load_data == r_sum) ? S_RUN : S_ERROR;
`endif
          default: ;
        endcase
      end else if (w_timeout) begin
        w_state_nxt = S_ERROR;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_count <= '0;
      r_timer <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum   <= w_sum_nxt;
`endif
    end
  end

  // Memory survives reset; stale contents are hidden by the length mask on the read side.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[r_count] <= bus.load_data;
  end

  assign bus.instruction = ((r_state == S_RUN) && (bus.instruction_address < r_len))
                           ? r_mem[bus.instruction_address] : HALT_WORD;
  assign bus.load_ready  = w_loading;
  assign bus.cpu_reset   = (r_state != S_RUN);
  assign bus.running     = (r_state == S_RUN);
  assign bus.error       = (r_state == S_ERROR);
  assign bus.byte_count  = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, masking, length-0, timeout, restart-in-RUN, reset mid-load.
module tb_prog_loader;
  localparam int unsigned TO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  prog_loader_if bus ();

  prog_loader #(.TIMEOUT_CYCLES(TO), .HALT_WORD(8'hFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    chk("ready_before_byte", bus.load_ready, 8'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.instruction_address = a;
    #1;
    chk(tag, bus.instruction, exp);
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.instruction_address = 8'h00;

    // Reset state
    #2;
    chk("rst_cpu_reset", bus.cpu_reset, 8'd1);
    chk("rst_running", bus.running, 8'd0);
    chk("rst_error", bus.error, 8'd0);
    chk("rst_ready", bus.load_ready, 8'd0);
    chk("rst_count", bus.byte_count, 8'd0);
    chk("rst_instr", bus.instruction, 8'hFF);
    tick(); tick();
    reset = 1'b0;

    // IDLE ignores bytes without load_start
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h07;
    tick(); tick(); tick();
    bus.load_valid = 1'b0;
    chk("idle_ready", bus.load_ready, 8'd0);
    chk("idle_count", bus.byte_count, 8'd0);

    // Normal load 03,00,15,C3
    start();
    chk("len_ready", bus.load_ready, 8'd1);
    chk("len_cpu_reset", bus.cpu_reset, 8'd1);
    send(8'h03); send(8'h00); send(8'h15); send(8'hC3);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("csum_wait_cpu_reset", bus.cpu_reset, 8'd1);
    send(8'hD8);
`endif
    chk("run_running", bus.running, 8'd1);
    chk("run_cpu_reset", bus.cpu_reset, 8'd0);
    chk("run_count", bus.byte_count, 8'd3);
    chk("run_ready", bus.load_ready, 8'd0);
    fetch(8'd0, 8'h00, "fetch0");
    fetch(8'd1, 8'h15, "fetch1");
    fetch(8'd2, 8'hC3, "fetch2");
    fetch(8'd3, 8'hFF, "fetch3_masked");
    fetch(8'd200, 8'hFF, "fetch200_masked");

    // load_start in RUN with simultaneous byte: byte ignored, back in LEN
    bus.instruction_address = 8'd1;
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hAA;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("restart_ready", bus.load_ready, 8'd1);
    chk("restart_cpu_reset", bus.cpu_reset, 8'd1);
    chk("restart_instr", bus.instruction, 8'hFF);
    chk("restart_count", bus.byte_count, 8'd0);
    chk("restart_running", bus.running, 8'd0);

    // Length 0 aborts on the transfer edge
    send(8'h00);
    chk("len0_error", bus.error, 8'd1);
    chk("len0_ready", bus.load_ready, 8'd0);
    chk("len0_instr", bus.instruction, 8'hFF);
    tick();
    chk("len0_error_held", bus.error, 8'd1);

    // Timeout after two of five data bytes
    start();
    chk("start_clears_error", bus.error, 8'd0);
    send(8'h05); send(8'h01); send(8'h02);
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    chk("to_not_yet_error", bus.error, 8'd0);
    chk("to_not_yet_ready", bus.load_ready, 8'd1);
    tick();
    chk("to_error", bus.error, 8'd1);
    chk("to_count", bus.byte_count, 8'd2);
    chk("to_cpu_reset", bus.cpu_reset, 8'd1);

    // Transfers restart the timeout counter; stale mem[2]=C3 stays masked
    start();
    send(8'h02);
    for (int i = 0; i < 15; i++) tick();
    send(8'h7E);
    for (int i = 0; i < 15; i++) tick();
    chk("slow_no_error", bus.error, 8'd0);
    send(8'h81);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hFF);
`endif
    chk("slow_running", bus.running, 8'd1);
    fetch(8'd0, 8'h7E, "slow_fetch0");
    fetch(8'd1, 8'h81, "slow_fetch1");
    fetch(8'd2, 8'hFF, "slow_fetch2_masked");

    // Reset mid-DATA
    start();
    send(8'h04); send(8'hAA);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", bus.load_ready, 8'd0);
    chk("mid_rst_count", bus.byte_count, 8'd0);
    chk("mid_rst_cpu_reset", bus.cpu_reset, 8'd1);
    tick();
    reset = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_ready", bus.load_ready, 8'd0);
    chk("post_rst_count", bus.byte_count, 8'd0);
    fetch(8'd0, 8'hFF, "post_rst_instr");
    bus.load_valid = 1'b0;

    // One-byte program after reset
    start();
    send(8'h01); send(8'h5A);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h5A);
`endif
    chk("one_running", bus.running, 8'd1);
    chk("one_count", bus.byte_count, 8'd1);
    fetch(8'd0, 8'h5A, "one_fetch0");
    fetch(8'd1, 8'hFF, "one_fetch1_masked");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum then good checksum
    start();
    send(8'h02); send(8'h11); send(8'h22); send(8'h34);
    chk("badsum_error", bus.error, 8'd1);
    chk("badsum_cpu_reset", bus.cpu_reset, 8'd1);
    fetch(8'd0, 8'hFF, "badsum_instr");
    start();
    send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    chk("goodsum_running", bus.running, 8'd1);
    fetch(8'd1, 8'h22, "goodsum_fetch1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
